ldst_control_sequencer: RTL and testbench
=========================================

Name: ldst_control_sequencer

Overview:
- Hardwired control-step sequencer for the load/store instruction group (ld, ldi, st, addi) of the single-bus Datapath.
- Replaces per-state testbench stimulus with an FSM that drives the Datapath control inputs one T-step per clock.
- Adds a memory ready handshake with wait states, a timeout watchdog, and illegal-opcode trapping.
- Sits between the IR opcode field and the Datapath control ports.

Parameters:
OPC_W, 5, opcode field width (IR[31:32-OPC_W])
OPC_LD, 5'b00000, ld opcode
OPC_LDI, 5'b00001, ldi opcode
OPC_ST, 5'b00010, st opcode
OPC_ADDI, 5'b00011, addi opcode
TMO_W, 4, width of memory-wait counter
TMO_MAX, 15, max wait cycles before fault (1..2^TMO_W-1)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
run  in  1  level; 1 = fetch/execute, 0 = stop at next instruction boundary
opcode  in  OPC_W  IR opcode bits, sampled in T3 onward
mem_ready  in  1  RAM handshake: read data valid / write accepted this cycle
PCout, MARin, IncPC, PCin, Zlowin, Zlowout  out  1 each  Datapath controls
MDRin, MDRout, MDMuxread, IRin, Yin, CSEout, ADD  out  1 each  Datapath controls
Gra, Grb, Rin, Rout, BAout, RAMread, RAMwrite  out  1 each  Datapath controls
busy  out  1  1 in any state except IDLE and FAULT
fault  out  1  sticky 1 in FAULT
fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
step  out  4  current state encoding (debug)

Behaviour:
- Reset (clear=0, async): state=IDLE, wait counter=0, fault_code=00. All outputs 0 while clear=0.
- Outputs are Moore-decoded from the registered state. The only exception is MDRin in RD_WAIT states, which equals mem_ready.
- States and asserted outputs:
  - IDLE: none. Goes to T0 when run=1.
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin.
  - F_WAIT: MDMuxread, RAMread; MDRin=mem_ready. Goes to T2 on mem_ready.
  - T2: MDRout, IRin.
  - T3: decode opcode.
    - ld/ldi/st: Grb, BAout, Yin.
    - addi: Grb, Rout, Yin.
    - Other opcode: T3 outputs 0; next state FAULT, fault_code=01.
  - T4: CSEout, ADD, Zlowin.
  - T5 for ldi/addi: Zlowout, Gra, Rin, then end-of-instruction.
  - T5 for ld/st: Zlowout, MARin.
  - T6 for ld (RD_WAIT): MDMuxread, RAMread; MDRin=mem_ready. Goes to T7 on mem_ready.
  - T6 for st: Gra, Rout, MDRin (MDMuxread=0).
  - T7 for ld: MDRout, Gra, Rin, then end-of-instruction.
  - T7 for st (WR_WAIT): RAMwrite held until mem_ready. End-of-instruction in the mem_ready cycle.
  - End-of-instruction: next state T0 if run=1, else IDLE. run=0 mid-instruction never aborts.
- Opcode is latched into an internal register at T3. Later steps use the latched value; opcode changes after T3 are ignored.
- Wait counter:
  - Cleared on entry to any wait state; increments each wait cycle with mem_ready=0.
  - If it reaches TMO_MAX without mem_ready, next state is FAULT with fault_code=10.
  - mem_ready in the same cycle the count hits TMO_MAX wins: no fault.
  - Zero-wait case: mem_ready=1 on the first wait cycle gives a 1-cycle wait state.
- FAULT: all controls 0; fault=1. Exits only via clear=0.
- Cycle counts with zero memory waits:
  - ldi/addi: 7 cycles (T0,T1,F_WAIT,T2,T3,T4,T5).
  - ld: 9 cycles.
  - st: 9 cycles.
- mem_ready outside wait states is ignored.
- Never asserted simultaneously:
  - RAMread and RAMwrite.
  - Rin and Rout.
  - More than one bus driver among PCout, Zlowout, MDRout, Rout, BAout, CSEout.

Test Plan:
- Reset mid-ld (clear=0 during RD_WAIT) -> all outputs 0 immediately (asynchronous); step=IDLE; fault=0.
- run=1, opcode=ldi, mem_ready=1 always -> exact 7-cycle control sequence as listed. T0 repeats on cycle 8. busy stays 1 throughout.
- opcode=ld, mem_ready low for 3 cycles in F_WAIT and 2 cycles in RD_WAIT -> F_WAIT lasts 4 cycles, RD_WAIT lasts 3. MDRin pulses only in each ready cycle. 14 cycles total.
- opcode=st, WR_WAIT with mem_ready=0 for 15 cycles -> FAULT, fault_code=10, RAMwrite drops.
- Repeat with mem_ready=1 on the 15th cycle -> no fault, next state T0.
- opcode=5'b11111 -> FAULT after T3, fault_code=01, no Rin/RAMwrite ever asserted.
- run dropped during T4 of addi -> T5 completes (Rin pulse), then IDLE. busy falls the following cycle.
- Re-raising run -> T0.
- Checker on all runs: no concurrent bus drivers; RAMread and RAMwrite never both 1.

Source files
------------

// File: rtl/ldst_control_sequencer.sv
// Hardwired T-step sequencer for ld/ldi/st/addi on the single-bus datapath.
// One control step per clock, with memory wait states, a wait watchdog and opcode trapping.
module ldst_control_sequencer #(
  parameter int              OPC_W    = 5,
  parameter logic [OPC_W-1:0] OPC_LD   = 5'b00000,
  parameter logic [OPC_W-1:0] OPC_LDI  = 5'b00001,
  parameter logic [OPC_W-1:0] OPC_ST   = 5'b00010,
  parameter logic [OPC_W-1:0] OPC_ADDI = 5'b00011,
  parameter int              TMO_W    = 4,
  parameter int              TMO_MAX  = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Zlowin,
  output logic             Zlowout,
  output logic             MDRin,
  output logic             MDRout,
  output logic             MDMuxread,
  output logic             IRin,
  output logic             Yin,
  output logic             CSEout,
  output logic             ADD,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             RAMread,
  output logic             RAMwrite,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [3:0]       step
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_FWAIT  = 4'd3,
    S_T2     = 4'd4,
    S_T3     = 4'd5,
    S_T4     = 4'd6,
    S_T5     = 4'd7,
    S_ST6    = 4'd8,
    S_RDWAIT = 4'd9,
    S_LD7    = 4'd10,
    S_WRWAIT = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [1:0]       fcode_q, fcode_d;
  logic             waiting, tmo;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opc_q   <= '0;
      fcode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      fcode_q <= fcode_d;
    end
  end

  assign waiting = (state_q == S_FWAIT) || (state_q == S_RDWAIT) || (state_q == S_WRWAIT);
  // The cycle that would take the count to TMO_MAX is the last one allowed; ready in it still wins.
  assign tmo     = !mem_ready && (cnt_q == TMO_W'(TMO_MAX - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = (waiting && !mem_ready) ? cnt_q + 1'b1 : '0;
    opc_d     = opc_q;
    fcode_d   = fcode_q;
    PCout     = 1'b0; MARin  = 1'b0; IncPC  = 1'b0; PCin      = 1'b0;
    Zlowin    = 1'b0; Zlowout = 1'b0; MDRin = 1'b0; MDRout    = 1'b0;
    MDMuxread = 1'b0; IRin   = 1'b0; Yin    = 1'b0; CSEout    = 1'b0;
    ADD       = 1'b0; Gra    = 1'b0; Grb    = 1'b0; Rin       = 1'b0;
    Rout      = 1'b0; BAout  = 1'b0; RAMread = 1'b0; RAMwrite = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1;
        state_d = S_FWAIT;
      end
      S_FWAIT: begin
        MDMuxread = 1'b1; RAMread = 1'b1; MDRin = mem_ready;
        if (mem_ready) state_d = S_T2;
        else if (tmo) begin state_d = S_FAULT; fcode_d = 2'b10; end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        opc_d = opcode;
        case (opcode)
          OPC_LD, OPC_LDI, OPC_ST: begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = S_T4;
          end
          OPC_ADDI: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = S_T4;
          end
          default: begin
            state_d = S_FAULT; fcode_d = 2'b01;
          end
        endcase
      end
      S_T4: begin
        CSEout = 1'b1; ADD = 1'b1; Zlowin = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (opc_q == OPC_LDI || opc_q == OPC_ADDI) begin
          Gra = 1'b1; Rin = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end else begin
          MARin = 1'b1;
          state_d = (opc_q == OPC_LD) ? S_RDWAIT : S_ST6;
        end
      end
      S_RDWAIT: begin
        MDMuxread = 1'b1; RAMread = 1'b1; MDRin = mem_ready;
        if (mem_ready) state_d = S_LD7;
        else if (tmo) begin state_d = S_FAULT; fcode_d = 2'b10; end
      end
      S_LD7: begin
        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        state_d = run ? S_T0 : S_IDLE;
      end
      S_ST6: begin
        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        state_d = S_WRWAIT;
      end
      S_WRWAIT: begin
        RAMwrite = 1'b1;
        if (mem_ready) state_d = run ? S_T0 : S_IDLE;
        else if (tmo) begin state_d = S_FAULT; fcode_d = 2'b10; end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fcode_q;
  assign step       = state_q;

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle control words
// from the step tables, then replayed against the sequencer cycle by cycle.
module tb_ldst_control_sequencer;

  localparam logic [19:0] M_PCOUT = 20'd1 << 0,  M_MARIN = 20'd1 << 1,  M_INCPC = 20'd1 << 2;
  localparam logic [19:0] M_PCIN  = 20'd1 << 3,  M_ZIN   = 20'd1 << 4,  M_ZOUT  = 20'd1 << 5;
  localparam logic [19:0] M_MDRIN = 20'd1 << 6,  M_MDROUT = 20'd1 << 7, M_MDMUX = 20'd1 << 8;
  localparam logic [19:0] M_IRIN  = 20'd1 << 9,  M_YIN   = 20'd1 << 10, M_CSE   = 20'd1 << 11;
  localparam logic [19:0] M_ADD   = 20'd1 << 12, M_GRA   = 20'd1 << 13, M_GRB   = 20'd1 << 14;
  localparam logic [19:0] M_RIN   = 20'd1 << 15, M_ROUT  = 20'd1 << 16, M_BAOUT = 20'd1 << 17;
  localparam logic [19:0] M_RAMRD = 20'd1 << 18, M_RAMWR = 20'd1 << 19;
  localparam logic [4:0]  LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADDI = 5'b00011;

  logic clock, clear, run, mem_ready;
  logic [4:0] opcode;
  logic PCout, MARin, IncPC, PCin, Zlowin, Zlowout, MDRin, MDRout, MDMuxread, IRin;
  logic Yin, CSEout, ADD, Gra, Grb, Rin, Rout, BAout, RAMread, RAMwrite, busy, fault;
  logic [1:0] fault_code;
  logic [3:0] step;
  logic [23:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] ctl;
    bit          mr;
    bit          run;
    logic [4:0]  opc;
    bit          busy;
    bit          flt;
    logic [1:0]  fc;
  } ent_t;
  ent_t q[$];

  ldst_control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Zlowin(Zlowin),
    .Zlowout(Zlowout), .MDRin(MDRin), .MDRout(MDRout), .MDMuxread(MDMuxread), .IRin(IRin),
    .Yin(Yin), .CSEout(CSEout), .ADD(ADD), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .RAMread(RAMread), .RAMwrite(RAMwrite), .busy(busy), .fault(fault),
    .fault_code(fault_code), .step(step)
  );

  assign obs = {fault, fault_code, busy, RAMwrite, RAMread, BAout, Rout, Rin, Grb, Gra, ADD,
                CSEout, Yin, IRin, MDMuxread, MDRout, MDRin, Zlowout, Zlowin, PCin, IncPC,
                MARin, PCout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Structural hazards that must never appear, whatever the instruction mix.
  always @(negedge clock) begin
    #2;
    if (clear) begin
      checks++;
      if ($countones({PCout, Zlowout, MDRout, Rout, BAout, CSEout}) > 1 ||
          (RAMread && RAMwrite) || (Rin && Rout)) begin
        errors++;
        $display("FAIL invariant bus=%b rd=%b wr=%b rin=%b rout=%b required exclusive",
                 {PCout, Zlowout, MDRout, Rout, BAout, CSEout}, RAMread, RAMwrite, Rin, Rout);
      end
    end
  end

  task automatic push_c(input logic [19:0] ctl, input bit mr, input logic [4:0] opc);
    ent_t e;
    e.ctl = ctl; e.mr = mr; e.run = 1'b1; e.opc = opc; e.busy = 1'b1; e.flt = 1'b0; e.fc = 2'b00;
    q.push_back(e);
  endtask

  task automatic push_idle(input bit r);
    ent_t e;
    e.ctl = '0; e.mr = 1'($urandom); e.run = r; e.opc = 5'($urandom); e.busy = 1'b0;
    e.flt = 1'b0; e.fc = 2'b00;
    q.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] code);
    ent_t e;
    for (int i = 0; i < 3; i++) begin
      e.ctl = '0; e.mr = 1'($urandom); e.run = 1'b1; e.opc = 5'($urandom); e.busy = 1'b0;
      e.flt = 1'b1; e.fc = code;
      q.push_back(e);
    end
  endtask

  // n not-ready cycles then one ready cycle; 15 straight not-ready cycles end in a timeout fault.
  task automatic wait_ph(input int n, input logic [19:0] base, input logic [19:0] rdy, output bit ok);
    for (int i = 0; i < ((n < 15) ? n : 15); i++) push_c(base, 1'b0, 5'($urandom));
    if (n >= 15) begin
      push_fault(2'b10);
      ok = 1'b0;
    end else begin
      push_c(base | rdy, 1'b1, 5'($urandom));
      ok = 1'b1;
    end
  endtask

  task automatic build(input logic [4:0] op, input int nf, input int nd, output bit ok);
    bit w;
    ok = 1'b0;
    push_c(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'($urandom), 5'($urandom));
    push_c(M_ZOUT | M_PCIN, 1'($urandom), 5'($urandom));
    wait_ph(nf, M_MDMUX | M_RAMRD, M_MDRIN, w);
    if (!w) return;
    push_c(M_MDROUT | M_IRIN, 1'($urandom), 5'($urandom));
    if (op == LD || op == LDI || op == ST) push_c(M_GRB | M_BAOUT | M_YIN, 1'($urandom), op);
    else if (op == ADDI)                   push_c(M_GRB | M_ROUT | M_YIN, 1'($urandom), op);
    else begin
      push_c('0, 1'($urandom), op);
      push_fault(2'b01);
      return;
    end
    push_c(M_CSE | M_ADD | M_ZIN, 1'($urandom), 5'($urandom));
    if (op == LDI || op == ADDI) begin
      push_c(M_ZOUT | M_GRA | M_RIN, 1'($urandom), 5'($urandom));
    end else begin
      push_c(M_ZOUT | M_MARIN, 1'($urandom), 5'($urandom));
      if (op == LD) begin
        wait_ph(nd, M_MDMUX | M_RAMRD, M_MDRIN, w);
        if (!w) return;
        push_c(M_MDROUT | M_GRA | M_RIN, 1'($urandom), 5'($urandom));
      end else begin
        push_c(M_GRA | M_ROUT | M_MDRIN, 1'($urandom), 5'($urandom));
        wait_ph(nd, M_RAMWR, '0, w);
        if (!w) return;
      end
    end
    ok = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    run = 1'b0; mem_ready = 1'b0; clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    q.delete();
    push_idle(1'b1);
  endtask

  task automatic test_reset();
    bit ok;
    clear = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = '0;
    #2;
    checks++;
    if (obs !== 24'h0 || step !== 4'd0) begin
      errors++; $display("FAIL reset_initial got %h step %0d required 0", obs, step);
    end
    do_reset();
    build(LD, 0, 10, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); run = q[i].run; opcode = q[i].opc; mem_ready = q[i].mr; #1;
      checks++;
      if (obs !== {q[i].flt, q[i].fc, q[i].busy, q[i].ctl}) begin
        errors++; $display("FAIL reset_pre cyc%0d got %h required %h", i, obs,
                           {q[i].flt, q[i].fc, q[i].busy, q[i].ctl});
      end
    end
    clear = 1'b0;
    #1;
    checks++;
    if (obs !== 24'h0 || step !== 4'd0) begin
      errors++; $display("FAIL reset_async got %h step %0d required 0", obs, step);
    end
  endtask

  task automatic test_ldi();
    bit ok;
    do_reset();
    build(LDI, 0, 0, ok);
    build(LDI, 0, 0, ok);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock); run = q[i].run; opcode = q[i].opc; mem_ready = (i == 3 || i == 10) ? 1'b1 : q[i].mr; #1;
      checks++;
      if (obs !== {q[i].flt, q[i].fc, q[i].busy, q[i].ctl}) begin
        errors++; $display("FAIL ldi cyc%0d got %h required %h", i, obs,
                           {q[i].flt, q[i].fc, q[i].busy, q[i].ctl});
      end
    end
  endtask

  task automatic test_ld_waits();
    bit ok;
    do_reset();
    build(LD, 3, 2, ok);
    build(ADDI, 0, 0, ok);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock); run = q[i].run; opcode = q[i].opc; mem_ready = q[i].mr; #1;
      checks++;
      if (obs !== {q[i].flt, q[i].fc, q[i].busy, q[i].ctl}) begin
        errors++; $display("FAIL ld_waits cyc%0d got %h required %h", i, obs,
                           {q[i].flt, q[i].fc, q[i].busy, q[i].ctl});
      end
    end
  endtask

  task automatic test_st_timeout(input int nd, input string tag);
    bit ok;
    do_reset();
    build(ST, 0, nd, ok);
    if (ok) build(LDI, 1, 0, ok);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock); run = q[i].run; opcode = q[i].opc; mem_ready = q[i].mr; #1;
      checks++;
      if (obs !== {q[i].flt, q[i].fc, q[i].busy, q[i].ctl}) begin
        errors++; $display("FAIL %s cyc%0d got %h required %h", tag, i, obs,
                           {q[i].flt, q[i].fc, q[i].busy, q[i].ctl});
      end
    end
  endtask

  task automatic test_illegal();
    bit ok;
    do_reset();
    build(5'b11111, 0, 0, ok);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock); run = q[i].run; opcode = q[i].opc; mem_ready = q[i].mr; #1;
      checks++;
      if (obs !== {q[i].flt, q[i].fc, q[i].busy, q[i].ctl}) begin
        errors++; $display("FAIL illegal cyc%0d got %h required %h", i, obs,
                           {q[i].flt, q[i].fc, q[i].busy, q[i].ctl});
      end
    end
  endtask

  task automatic test_run_drop();
    bit ok;
    int b;
    do_reset();
    b = q.size();
    build(ADDI, 0, 0, ok);
    q[b + 5].run = 1'b0;
    q[b + 6].run = 1'b0;
    push_idle(1'b0);
    push_idle(1'b0);
    push_idle(1'b1);
    build(LDI, 0, 0, ok);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock); run = q[i].run; opcode = q[i].opc; mem_ready = q[i].mr; #1;
      checks++;
      if (obs !== {q[i].flt, q[i].fc, q[i].busy, q[i].ctl}) begin
        errors++; $display("FAIL run_drop cyc%0d got %h required %h", i, obs,
                           {q[i].flt, q[i].fc, q[i].busy, q[i].ctl});
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [4:0] op;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      ok = 1'b1;
      for (int k = 0; k < 10 && ok; k++) begin
        op = 5'($urandom_range(0, 3));
        build(op, $urandom_range(0, 4), ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 4), ok);
        if (ok && $urandom_range(0, 3) == 0) begin
          q[q.size() - 1].run = 1'b0;
          push_idle(1'b0);
          push_idle(1'b1);
        end
      end
      for (int i = 0; i < q.size(); i++) begin
        @(negedge clock); run = q[i].run; opcode = q[i].opc; mem_ready = q[i].mr; #1;
        checks++;
        if (obs !== {q[i].flt, q[i].fc, q[i].busy, q[i].ctl}) begin
          errors++; $display("FAIL random r%0d cyc%0d got %h required %h", r, i, obs,
                             {q[i].flt, q[i].fc, q[i].busy, q[i].ctl});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_ld_waits();
    test_st_timeout(15, "st_timeout");
    test_st_timeout(14, "st_late_ready");
    test_illegal();
    test_run_drop();
    test_random();
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
